// File: rtl/risc5_pkg.sv
// Shared definitions for the RAM arbiter: bus widths and the arbiter
// FSM state encoding.
package risc5_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        VID  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arb_tmo.sv
// arb_tmo: watchdog for a RAM grant. Down-counter reloaded on every ack and
// whenever no grant is active; `expire` flags the TMO_CYCLES-th strobe cycle
// without an ack. Only instantiated when RAM_ARB_TIMEOUT_EN is defined.
module arb_tmo #(
    parameter int TMO_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic ack,
    output logic expire
);

    localparam int CNT_W = $clog2(TMO_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TMO_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Terminal count reached in a strobe cycle that carries no real ack.
    assign expire = run && !ack && (cnt == '0);

    // Count down while a grant waits; reload when idle, acked or expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (!run || ack || expire) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ram_arb.sv
// ram_arb: shares the single RAM slave port between the CPU (single
// accesses) and the video refresh master (fixed-length read bursts).
// Video has priority, but after every burst the CPU is owed one slot.
// Each grant returns to IDLE for one bubble cycle.
// Optional feature: define RAM_ARB_TIMEOUT_EN to build the ack watchdog
// (arb_tmo) and the sticky tmo_err flag; otherwise tmo_err is tied low.
module ram_arb
    import risc5_pkg::*;
#(
    parameter int BURST      = 8,
    parameter int TMO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_stb,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    input  logic              vid_stb,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_dout,
    output logic              vid_ack,
    output logic              ram_stb,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_ack,
    output logic              tmo_err
);

    localparam int BEAT_W = $clog2(BURST);
    localparam int BASE_W = ADDR_W - BEAT_W;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);

    arb_state_t        state;
    logic              ram_stb_q;
    logic [BEAT_W-1:0] beat;
    logic [BASE_W-1:0] base;
    logic              cpu_owed;
    logic              tmo_hit;
    logic              done;
    logic [DATA_W-1:0] rd_data;

    // Low address bits of a burst request are replaced by the beat counter.
    logic unused_vid_low;
    assign unused_vid_low = ^vid_addr[BEAT_W-1:0];

`ifdef RAM_ARB_TIMEOUT_EN
    logic tmo_err_q;

    arb_tmo #(
        .TMO_CYCLES(TMO_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state != IDLE),
        .ack    (ram_ack),
        .expire (tmo_hit)
    );

    // Sticky error: once a grant has timed out it stays flagged until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_err_q <= 1'b0;
        end else if (tmo_hit) begin
            tmo_err_q <= 1'b1;
        end
    end

    assign tmo_err = tmo_err_q;
`else
    // Keeps the parameter referenced when no watchdog is built.
    localparam int unused_tmo_cycles = TMO_CYCLES;

    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif

    // A grant finishes a word on a real ack or on a watchdog expiry.
    assign done = ram_ack || tmo_hit;

    // Grant sequencing: priority, burst beat counting and the owed CPU slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ram_stb_q <= 1'b0;
            beat      <= '0;
            base      <= '0;
            cpu_owed  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Video wins unless the CPU is owed a slot and actually
                    // asking for it; an unclaimed owed slot does not block video.
                    if (vid_stb && (!cpu_owed || !cpu_stb)) begin
                        state     <= VID;
                        ram_stb_q <= 1'b1;
                        beat      <= '0;
                        base      <= vid_addr[ADDR_W-1:BEAT_W];
                    end else if (cpu_stb) begin
                        state     <= CPU;
                        ram_stb_q <= 1'b1;
                        cpu_owed  <= 1'b0;
                    end
                end
                CPU: begin
                    if (done) begin
                        state     <= IDLE;
                        ram_stb_q <= 1'b0;
                    end
                end
                VID: begin
                    if (done) begin
                        beat <= beat + 1'b1;
                        if (beat == BEAT_LAST) begin
                            state     <= IDLE;
                            ram_stb_q <= 1'b0;
                            cpu_owed  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    ram_stb_q <= 1'b0;
                end
            endcase
        end
    end

    assign ram_stb = ram_stb_q;

    // A timed-out word returns zero rather than whatever the bus floats to.
    assign rd_data  = tmo_hit ? '0 : ram_dout;
    assign cpu_dout = rd_data;
    assign vid_dout = rd_data;

    // RAM request mux and ack routing to the granted master only.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        cpu_ack  = 1'b0;
        vid_ack  = 1'b0;
        case (state)
            CPU: begin
                ram_we   = cpu_we;
                ram_addr = cpu_addr;
                ram_din  = cpu_din;
                cpu_ack  = done;
            end
            VID: begin
                ram_addr = {base, beat};
                vid_ack  = done;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/ram_arb.md
# ram_arb

Two-master arbiter sharing the single RAM slave port between the CPU and a read-only video refresh master. It sits between the CPU/address decoder (`ram_stb` path) and the `ram` instance. It sequences fixed-length video read bursts and single CPU accesses, and forwards data and acknowledges to the owning master. Video has priority, with one guaranteed CPU slot after every burst to prevent CPU starvation.

## Interface
Parameters:
- `BURST`, 8: words per video burst; power of two, 2..64.
- `TMO_CYCLES`, 255: timeout limit in cycles; used only with the timeout feature.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_stb` in 1: CPU request to RAM (decoded `ram_stb`); held until `cpu_ack`.
- `cpu_we` in 1: CPU write enable.
- `cpu_addr` in 22: CPU word address [23:2].
- `cpu_din` in 32: CPU write data.
- `cpu_dout` out 32: CPU read data.
- `cpu_ack` out 1: one-cycle completion pulse to CPU.
- `vid_stb` in 1: video burst request; held until the last `vid_ack` of the burst.
- `vid_addr` in 22: burst start word address; low log2(BURST) bits are ignored (treated as 0).
- `vid_dout` out 32: video read data.
- `vid_ack` out 1: one-cycle pulse per burst word.
- `ram_stb` out 1: RAM strobe.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out 22: RAM word address.
- `ram_din` out 32: RAM write data.
- `ram_dout` in 32: RAM read data.
- `ram_ack` in 1: RAM acknowledge, one pulse per word.
- `tmo_err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, CPU, VID.
- Behaviour in IDLE:
  - If `vid_stb` and not `cpu_owed`: go to VID, clear the beat counter, latch `vid_addr` upper bits.
  - Else if `cpu_stb`: go to CPU, clear `cpu_owed`.
  - Else if `vid_stb`: go to VID. This covers `cpu_owed` set with no CPU request pending.
- Behaviour in CPU:
  - `ram_stb`=1; `ram_we`, `ram_addr` and `ram_din` are taken from the CPU inputs.
  - On `ram_ack`: `cpu_ack`=1 in the same cycle, then go to IDLE.
- Behaviour in VID:
  - `ram_stb`=1, `ram_we`=0.
  - `ram_addr` = {latched base, beat counter}.
  - Each `ram_ack`: `vid_ack`=1 in the same cycle and the counter increments.
  - On the ack of beat BURST-1: go to IDLE and set `cpu_owed`.
  - Address wraps within the aligned burst only; the counter never carries into the base.
- In IDLE, `ram_stb`=0. Every grant is followed by exactly one IDLE bubble cycle.
- `cpu_dout` and `vid_dout` are combinational copies of `ram_dout`. They are valid only while the matching ack is high.
- Acks are never forwarded to a master that is not granted. `ram_ack` in IDLE is ignored.
- Requests arriving mid-grant wait in place; neither master is ever aborted.
- Dropping `vid_stb` mid-burst is a protocol violation: the burst still completes BURST beats.
- `rst_n` low: FSM returns to IDLE immediately. Counter, `cpu_owed` and `tmo_err` clear; all strobes and acks go to 0, including mid-burst.

## Timing
- Reset values: `ram_stb`, `ram_we`, `cpu_ack`, `vid_ack`, `tmo_err` = 0; `ram_addr`, `ram_din` = 0.
- Request-to-strobe latency: `*_stb` sampled high in IDLE gives `ram_stb` high the next cycle. Strobe is driven from a state register, not a comb path from inputs.
- Ack latency: zero cycles from `ram_ack` to master ack.
- Best-case throughput: with a RAM that acks in the first strobe cycle, a burst takes 1+BURST cycles and a CPU access takes 2 cycles, both including the IDLE bubble.
- Simultaneous `cpu_stb` and `vid_stb` in IDLE: VID wins unless `cpu_owed`=1.

## Configuration
- Macro `RAM_ARB_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in CPU and VID and reloads on each `ram_ack`.
  - When it reaches `TMO_CYCLES` with no ack, the arbiter generates the master ack itself, forces the data to 32'h0 and sets `tmo_err`. `tmo_err` clears only on reset.
  - A VID timeout counts as a beat.
- Undefined: no counter is built; `tmo_err` is tied to 0 and the arbiter waits indefinitely for `ram_ack`.

## Structure
- Shared package `risc5_pkg` holds:
  - the FSM state encoding (IDLE=2'd0, CPU=2'd1, VID=2'd2);
  - the address width constant (22);
  - the data width constant (32).
- One sub-module, `arb_tmo`, for the timeout counter. It is instantiated only under `RAM_ARB_TIMEOUT_EN`.
- Muxing and FSM stay in `ram_arb`.

## Test plan
- CPU write alone: `cpu_stb`=1, `cpu_we`=1, addr 22'h000010, din 32'hDEADBEEF; RAM acks after 3 cycles → `ram_stb` rises 1 cycle after the request, one `cpu_ack`, RAM word 0x10 = DEADBEEF.
- Video burst (BURST=8): `vid_addr`=22'h000103, RAM acks every cycle → `ram_addr` sequence 0x100..0x107, 8 `vid_ack` pulses, 9 cycles total.
- Contention: `cpu_stb` and `vid_stb` asserted in the same cycle, both held → VID burst, then CPU access, then next VID burst; CPU is never starved.
- Reset mid-burst: `rst_n` low at beat 3 → `ram_stb`=0 and `vid_ack`=0 immediately. After release, a new burst restarts at beat 0.
- Stray ack: `ram_ack` pulsed in IDLE → no `cpu_ack` and no `vid_ack`.
- With `RAM_ARB_TIMEOUT_EN` and TMO_CYCLES=16: RAM never acks the CPU read → `cpu_ack` after 16 cycles, `cpu_dout`=0, `tmo_err`=1 until reset.
